// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer in front of CORE.
// Holds core_start low for ARM_CYC cycles after go, releases it and counts
// RUN cycles until halt, PC stall or budget exhaustion, then reports status.
// Optional feature macro: CORE_RUN_CTRL_STALL_DETECT_EN (PC-stall detection).
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for go
// ARM   | core_start low for ARM_CYC cycles, status cleared
// RUN   | core running, cycles counting, end conditions evaluated
// DONE  | run finished, core_start kept high, status and cycles frozen
module core_run_ctrl #(
  parameter int IMW        = 4,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 10,
  parameter int ARM_CYC    = 1,
  parameter int STALL_CYC  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic           halt,
  input  logic [IMW-1:0] pc,
  output logic           core_start,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [CW-1:0]  cycles
);

  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYC - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (MAX_CYCLES < 1 || MAX_CYCLES > (2 ** CW) - 1) begin : g_bad_max
    $error("core_run_ctrl: MAX_CYCLES out of range");
  end
  if (ARM_CYC < 1) begin : g_bad_arm
    $error("core_run_ctrl: ARM_CYC must be >= 1");
  end
  if (STALL_CYC < 1) begin : g_bad_stall
    $error("core_run_ctrl: STALL_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   arm_cnt;
  logic            stall_hit;
  logic            run_end;
  logic            run_timeout;
  logic            arm_entry;

  assign arm_entry = (state == IDLE || state == DONE) && go;

`ifdef CORE_RUN_CTRL_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYC - 1);

  logic [IMW-1:0] prev_pc;
  logic           prev_valid;
  logic [SW-1:0]  stall_cnt;
  logic           pc_same;

  assign pc_same   = prev_valid && (pc == prev_pc);
  // The run ends on the edge where the stall count would reach STALL_CYC.
  assign stall_hit = pc_same && (stall_cnt == STALL_LAST);

  // Previous-PC tracking and stall counter, restarted for every run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (arm_entry) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (state == RUN) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      stall_cnt  <= pc_same ? stall_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_pc;

  assign unused_pc = ^pc;
  assign stall_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and end-condition priority (halt, stall, budget).
  always_comb begin
    next_state  = state;
    run_end     = 1'b0;
    run_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (go) next_state = ARM;
      end
      ARM: begin
        if (arm_cnt == '0) next_state = RUN;
      end
      RUN: begin
        if (halt) begin
          run_end = 1'b1;
        end else if (stall_hit) begin
          run_end = 1'b1;
        end else if (cycles == MAX_LAST) begin
          run_end     = 1'b1;
          run_timeout = 1'b1;
        end
        if (run_end) next_state = DONE;
      end
      DONE: begin
        if (go) next_state = ARM;
      end
      default: next_state = IDLE;
    endcase
  end

  // ARM down-counter: loaded on entry, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= '0;
    end else if (arm_entry) begin
      arm_cnt <= ARM_LOAD;
    end else if (state == ARM && arm_cnt != '0) begin
      arm_cnt <= arm_cnt - 1'b1;
    end
  end

  // Registered outputs derived from the next state; status cleared on ARM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
    end else begin
      core_start <= (next_state == RUN) || (next_state == DONE);
      busy       <= (next_state == ARM) || (next_state == RUN);
      done       <= (next_state == DONE);
      if (arm_entry) begin
        timeout <= 1'b0;
        cycles  <= '0;
      end else if (state == RUN) begin
        cycles <= cycles + 1'b1;
        if (run_timeout) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller that sits in front of `CORE` and sequences a program run in hardware instead of by bench delays. On a `go` request it holds the core's `start` low for a programmable number of cycles, then releases it and counts execution cycles. The run ends on an explicit halt, a PC self-loop, or a cycle-budget timeout, and the controller then reports status and the cycle count. It is the parametrised successor to the fixed start-pulse/fixed-duration run used for `CORE` simulation, and it is usable both on FPGA and in benches.

## Interface
Parameters:
- `IMW`, 4: PC width; matches `CORE` instruction-memory address width.
- `CW`, 16: cycle counter width.
- `MAX_CYCLES`, 10: run budget in clock cycles; 1 ≤ MAX_CYCLES ≤ 2^CW−1.
- `ARM_CYC`, 1: cycles `core_start` is held low before a run; ≥ 1.
- `STALL_CYC`, 3: consecutive unchanged-PC cycles that count as a halt; ≥ 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: run request; sampled only in IDLE or DONE.
- `halt`, in, 1: core halt indication; sampled in RUN.
- `pc`, in, IMW: core program counter; sampled in RUN.
- `core_start`, out, 1: drives `CORE.start`.
- `busy`, out, 1: high in ARM and RUN.
- `done`, out, 1: high in DONE, held until the next accepted `go`.
- `timeout`, out, 1: qualifies `done`; high means the budget was exhausted.
- `cycles`, out, CW: number of RUN cycles in the current or last run.

## Operation
- All outputs reset to 0: `core_start`, `busy`, `done`, `timeout` and `cycles`. The state resets to IDLE.
- States and transitions:
  - IDLE → ARM on `go`=1.
  - ARM → RUN after ARM_CYC cycles.
  - RUN → DONE on an end condition.
  - DONE → ARM on `go`=1.
- IDLE: `core_start`=0.
- ARM: `core_start`=0, `busy`=1. `done`, `timeout` and `cycles` are cleared on entry. An internal counter counts ARM_CYC cycles.
- RUN: `core_start`=1, `busy`=1. `cycles` increments by 1 at every RUN clock edge, including the terminating edge.
- End conditions are evaluated at each RUN edge, in this priority:
  1. `halt`=1.
  2. PC stall detected (see Configuration).
  3. `cycles`==MAX_CYCLES−1, meaning this edge is the MAX_CYCLES-th. This condition sets `timeout`=1.
- A halt or stall on the same edge as budget exhaustion wins, and `timeout` stays 0.
- DONE: `core_start` stays 1 so that core state remains inspectable. `busy`=0, `done`=1, and `cycles` is frozen.
- `go` is ignored in ARM and RUN. A `go` in DONE restarts the run, and ARM re-resets the core.
- `rst_n` asserted at any time, including mid-RUN, returns immediately to the reset values. `core_start` dropping to 0 also resets the core.
- `cycles` never wraps, because MAX_CYCLES ≤ 2^CW−1 bounds it.

## Timing
- `go` high at edge N: ARM state from N, with `busy`=1 after edge N.
- `core_start` rises after edge N+ARM_CYC, which is the first RUN cycle.
- `halt` high at RUN edge K (the K-th RUN edge): after that edge `done`=1 and `cycles`=K.
- Timeout: after the MAX_CYCLES-th RUN edge, `done`=1, `timeout`=1 and `cycles`=MAX_CYCLES.
- Stall: a stall counter increments when `pc` equals the PC registered on the previous RUN edge, and clears otherwise. The first RUN edge has no valid previous PC and never counts. The counter ends the run on the edge where it reaches STALL_CYC.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CORE_RUN_CTRL_STALL_DETECT_EN` defined: the PC-stall end condition, the previous-PC register and the stall counter are compiled in.
- Not defined: these are removed, and runs end only on `halt` or timeout. `STALL_CYC` is then unused.

## Test plan
- Reset/idle: `rst_n`=0, then 1, with `go`=0 for 5 cycles. All outputs stay 0.
- Halt: defaults, `go` pulse, `halt` raised on the 4th RUN edge. `core_start` rises 1 cycle after `go`. The run ends with `done`=1, `timeout`=0 and `cycles`=4.
- Timeout: `pc` keeps changing and `halt`=0. The run ends with `done`=1, `timeout`=1, `cycles`=10 and `core_start` still 1.
- Stall (macro on): `pc` sequence 0,1,2,2,2,2. The run ends when the stall counter reaches 3, with `cycles`=6. With the macro off, the same stimulus times out at `cycles`=10.
- Simultaneous events: `halt`=1 exactly on the 10th RUN edge gives `timeout`=0 and `cycles`=10. A `go` during RUN is ignored.
- Restart/reset: `go` in DONE with ARM_CYC=3 gives `core_start`=0 for 3 cycles, with `done`, `timeout` and `cycles` cleared. `rst_n` asserted mid-RUN takes all outputs to 0 asynchronously.
